// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source select, load size and FSM state.
package wb_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_LINK = 2'd2,
    SRC_RSVD = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

endpackage

// File: rtl/wb_stage_mc_load_extract.sv
// Load lane extraction and sign/zero extension for returned memory data.
module load_extract
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_ext
);

  logic [OFF_W-1:0]  w_lane;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_shifted;
  logic              w_msb;

  // A full-width mask means no extension; that covers word on 32-bit and double on 64-bit.
  always_comb begin
    w_lane = '0;
    w_mask = '1;
    case (i_size)
      LD_B: begin
        w_lane = i_offset;
        w_mask = DATA_W'(8'hFF);
      end
      LD_H: begin
        w_lane = i_offset & ~OFF_W'(1);
        w_mask = DATA_W'(16'hFFFF);
      end
      LD_W: begin
        w_lane = i_offset & ~OFF_W'(3);
        w_mask = (DATA_W == 64) ? DATA_W'(32'hFFFF_FFFF) : '1;
      end
      default: begin
        w_lane = '0;
        w_mask = '1;
      end
    endcase
  end

  assign w_shifted = i_data >> {w_lane, 3'b000};
  // Top set bit of the mask selects the lane MSB.
  assign w_msb     = |(w_shifted & (w_mask ^ (w_mask >> 1)));
  assign o_ext     = (w_shifted & w_mask) | ({DATA_W{w_msb & ~i_unsigned}} & ~w_mask);

endmodule

// File: rtl/wb_stage_mc.sv
// MIPS writeback stage: selects ALU/load/link result, holds loads until data returns.
// state        | meaning
// ST_IDLE      | ready for a bundle; ALU/LINK results written on the next edge
// ST_WAIT_MEM  | load accepted, waiting for mem_rdata_valid (or flush)
module wb_stage_mc
  import wb_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int REG_ADDR_W        = 5,
  parameter int CNT_W             = 32,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wb_en,
  input  logic [1:0]            in_src_sel,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_link_value,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]     wb_value,
  output logic                  retire,
  output logic [CNT_W-1:0]      retire_count,
  output logic                  busy
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [OFF_W-1:0]      r_ld_off;
  logic [1:0]            r_ld_size;
  logic                  r_ld_uns;
  logic [REG_ADDR_W-1:0] r_ld_dest;
  logic                  r_ld_wen;

  logic                  w_accept;
  logic                  w_is_load;
  logic                  w_mem_done;
  logic                  w_complete;
  logic                  w_wen_raw;
  logic                  w_wen;
  logic [REG_ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0]     w_value;
  logic [DATA_W-1:0]     w_ext;

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_WAIT_MEM);
  assign w_is_load  = (in_src_sel == SRC_MEM);
  assign w_accept   = in_valid & in_ready & ~flush;
  assign w_mem_done = busy & mem_rdata_valid & ~flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept && w_is_load)     w_state_nxt = ST_WAIT_MEM;
      ST_WAIT_MEM: if (flush || mem_rdata_valid) w_state_nxt = ST_IDLE;
      default:                                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_complete = (w_accept & ~w_is_load) | w_mem_done;
    if (w_mem_done) begin
      w_dest    = r_ld_dest;
      w_wen_raw = r_ld_wen;
      w_value   = w_ext;
    end else begin
      w_dest    = in_dest;
      w_wen_raw = in_wb_en;
      w_value   = (in_src_sel == SRC_LINK) ? in_link_value : in_alu_result;
    end
    w_wen = w_wen_raw & ~((ZERO_REG_SUPPRESS != 0) && (w_dest == '0));
  end

  load_extract #(.DATA_W(DATA_W)) u_extract (
    .i_data     (mem_rdata),
    .i_offset   (r_ld_off),
    .i_size     (r_ld_size),
    .i_unsigned (r_ld_uns),
    .o_ext      (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_off  <= '0;
      r_ld_size <= '0;
      r_ld_uns  <= 1'b0;
      r_ld_dest <= '0;
      r_ld_wen  <= 1'b0;
    end else if (w_accept && w_is_load) begin
      r_ld_off  <= in_alu_result[OFF_W-1:0];
      r_ld_size <= in_ld_size;
      r_ld_uns  <= in_ld_unsigned;
      r_ld_dest <= in_dest;
      r_ld_wen  <= in_wb_en;
    end
  end

  // Destination and value hold their last written contents when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en        <= 1'b0;
      wb_dest      <= '0;
      wb_value     <= '0;
      retire       <= 1'b0;
      retire_count <= '0;
    end else begin
      wb_en  <= w_complete & w_wen;
      retire <= w_complete;
      if (w_complete && w_wen) begin
        wb_dest  <= w_dest;
        wb_value <= w_value;
      end
      if (w_complete) retire_count <= retire_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage_mc.sv
// Scoreboard bench for wb_stage_mc: driver predicts results from a load/select model, monitor compares.
module tb_wb_stage_mc;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_wb_en = 1'b0;
  logic [1:0]        in_src_sel = '0;
  logic [1:0]        in_ld_size = '0;
  logic              in_ld_unsigned = 1'b0;
  logic [DATA_W-1:0] in_alu_result = '0;
  logic [DATA_W-1:0] in_link_value = '0;
  logic [RA_W-1:0]   in_dest = '0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rdata_valid = 1'b0;
  logic              wb_en;
  logic [RA_W-1:0]   wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              retire;
  logic [CNT_W-1:0]  retire_count;
  logic              busy;

  always #5 clk = ~clk;

  wb_stage_mc #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .CNT_W(CNT_W), .ZERO_REG_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_src_sel(in_src_sel), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_alu_result(in_alu_result),
    .in_link_value(in_link_value), .in_dest(in_dest), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .wb_en(wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value), .retire(retire), .retire_count(retire_count), .busy(busy)
  );

  typedef struct {
    bit          wen;
    logic [4:0]  dest;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned m_count = 0;
  logic [4:0]  m_last_dest = '0;
  logic [31:0] m_last_val = '0;
  bit          m_waiting = 0;
  logic [31:0] m_ld_addr;
  logic [1:0]  m_ld_size;
  bit          m_ld_uns;
  logic [4:0]  m_ld_dest;
  bit          m_ld_wen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Load result from plain arithmetic on the little-endian lane.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [31:0] data,
                                           input logic [1:0] size, input bit uns);
    longint unsigned off, lane, bits, v;
    off = longint'(addr % 4);
    case (size)
      2'd0:    begin lane = off;            bits = 8;  end
      2'd1:    begin lane = off - (off % 2); bits = 16; end
      default: begin lane = 0;              bits = 32; end
    endcase
    v = (longint'(data) >> (8 * lane)) % (64'd1 << bits);
    if (!uns && bits < 32 && v >= (64'd1 << (bits - 1)))
      v = v + (64'd1 << 32) - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic void push_exp(input bit wen, input logic [4:0] dest, input logic [31:0] val);
    exp_t e;
    e.wen  = wen && (dest != 5'd0);
    e.dest = dest;
    e.val  = val;
    q.push_back(e);
  endfunction

  task automatic step(input bit v, input logic [1:0] src, input logic [1:0] size, input bit uns,
                      input logic [31:0] alu, input logic [31:0] link, input logic [4:0] dest,
                      input bit wen, input bit fl, input bit mrv, input logic [31:0] md);
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(!m_waiting));
    check("busy", 64'(busy), 64'(m_waiting));
    in_valid = v; in_src_sel = src; in_ld_size = size; in_ld_unsigned = uns;
    in_alu_result = alu; in_link_value = link; in_dest = dest; in_wb_en = wen;
    flush = fl; mem_rdata_valid = mrv; mem_rdata = md;
    if (m_waiting) begin
      if (fl) m_waiting = 0;
      else if (mrv) begin
        push_exp(m_ld_wen, m_ld_dest, ref_load(m_ld_addr, md, m_ld_size, m_ld_uns));
        m_waiting = 0;
      end
    end else if (v && !fl) begin
      if (src == 2'd1) begin
        m_waiting = 1;
        m_ld_addr = alu; m_ld_size = size; m_ld_uns = uns; m_ld_dest = dest; m_ld_wen = wen;
      end else begin
        push_exp(wen, dest, (src == 2'd2) ? link : alu);
      end
    end
  endtask

  task automatic idle();
    step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 0; flush = 0; mem_rdata_valid = 0; in_wb_en = 0;
    q.delete();
    m_count = 0; m_last_dest = '0; m_last_val = '0; m_waiting = 0;
    @(negedge clk);
    check("rst_wb_en", 64'(wb_en), 64'(0));
    check("rst_wb_dest", 64'(wb_dest), 64'(0));
    check("rst_wb_value", 64'(wb_value), 64'(0));
    check("rst_retire", 64'(retire), 64'(0));
    check("rst_retire_count", 64'(retire_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      if (retire === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_retire: got retire=1 expected no pending instruction");
        end else begin
          e = q.pop_front();
          m_count++;
          check("wb_en", 64'(wb_en), 64'(e.wen));
          if (e.wen) begin
            m_last_dest = e.dest;
            m_last_val  = e.val;
          end
          check("wb_dest", 64'(wb_dest), 64'(m_last_dest));
          check("wb_value", 64'(wb_value), 64'(m_last_val));
        end
      end else begin
        check("wb_en_no_retire", 64'(wb_en), 64'(0));
      end
      check("retire_count", 64'(retire_count), 64'(m_count));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // ALU back-to-back
    step(1, 2'd0, 2'd0, 0, 32'h11, 32'h0, 5'd4, 1, 0, 0, 32'h0);
    step(1, 2'd0, 2'd0, 0, 32'h22, 32'h0, 5'd5, 1, 0, 0, 32'h0);
    step(1, 2'd0, 2'd0, 0, 32'h33, 32'h0, 5'd6, 1, 0, 0, 32'h0);
    idle();
    check("alu_b2b_value", 64'(wb_value), 64'(32'h33));
    check("alu_b2b_dest", 64'(wb_dest), 64'(6));
    check("alu_b2b_count", 64'(retire_count), 64'(3));

    // signed then unsigned byte load, data 3 cycles after accept
    step(1, 2'd1, 2'd0, 0, 32'h1003, 32'h0, 5'd7, 1, 0, 0, 32'h0);
    idle(); idle();
    step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'h80FF_0000);
    idle();
    check("byte_signed", 64'(wb_value), 64'(32'hFFFF_FF80));
    check("byte_signed_wen", 64'(wb_en), 64'(1));
    step(1, 2'd1, 2'd0, 1, 32'h1003, 32'h0, 5'd7, 1, 0, 0, 32'h0);
    idle(); idle();
    step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'h80FF_0000);
    idle();
    check("byte_unsigned", 64'(wb_value), 64'(32'h0000_0080));

    // half loads at minimum latency
    step(1, 2'd1, 2'd1, 0, 32'h2002, 32'h0, 5'd8, 1, 0, 0, 32'h0);
    step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'h8001_1234);
    idle();
    check("half_hi_signed", 64'(wb_value), 64'(32'hFFFF_8001));
    step(1, 2'd1, 2'd1, 0, 32'h2000, 32'h0, 5'd8, 1, 0, 0, 32'h0);
    step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'h8001_1234);
    idle();
    check("half_lo_signed", 64'(wb_value), 64'(32'h0000_1234));

    // link and zero register
    step(1, 2'd2, 2'd0, 0, 32'hDEAD, 32'h0040_0008, 5'd31, 1, 0, 0, 32'h0);
    idle();
    check("link_value", 64'(wb_value), 64'(32'h0040_0008));
    check("link_wen", 64'(wb_en), 64'(1));
    step(1, 2'd0, 2'd0, 0, 32'h55, 32'h0, 5'd0, 1, 0, 0, 32'h0);
    idle();
    check("zero_dest_wen", 64'(wb_en), 64'(0));
    check("zero_dest_retire", 64'(retire), 64'(1));

    // flush in WAIT_MEM with simultaneous data, then a stray return in IDLE
    step(1, 2'd1, 2'd2, 0, 32'h3000, 32'h0, 5'd9, 1, 0, 0, 32'h0);
    idle();
    step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 1, 1, 32'h1234_5678);
    idle();
    check("flush_no_retire", 64'(retire), 64'(0));
    check("flush_no_wen", 64'(wb_en), 64'(0));
    step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'hAAAA_5555);
    idle();
    check("stray_no_retire", 64'(retire), 64'(0));

    // flush in IDLE drops the bundle
    step(1, 2'd0, 2'd0, 0, 32'h77, 32'h0, 5'd3, 1, 1, 0, 32'h0);
    idle();
    check("idle_flush_no_retire", 64'(retire), 64'(0));

    // reset in the middle of a load
    step(1, 2'd1, 2'd2, 0, 32'h4000, 32'h0, 5'd10, 1, 0, 0, 32'h0);
    idle();
    do_reset();
    step(1, 2'd0, 2'd0, 0, 32'h99, 32'h0, 5'd2, 1, 0, 0, 32'h0);
    idle();
    check("post_reset_value", 64'(wb_value), 64'(32'h99));
    check("post_reset_count", 64'(retire_count), 64'(1));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), $urandom, $urandom,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0), $urandom);
    end
    if (m_waiting) step(0, 2'd0, 2'd0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, $urandom);
    idle(); idle(); idle();
    check("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
